// File: rtl/axi_write_arbiter.sv
// AXI write-path sequencer: round-robin AW arbitration between two masters,
// slave decode on the winner's address, and AW/W/B phase routing with a
// per-phase watchdog that aborts a stalled transaction.
module axi_write_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 1023,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  AWVALID_M0,
    input  logic [ADDR_WIDTH-1:0] AWADDR_M0,
    input  logic                  AWVALID_M1,
    input  logic [ADDR_WIDTH-1:0] AWADDR_M1,
    input  logic                  AWREADY_SEL,
    input  logic                  WVALID_SEL,
    input  logic                  WREADY_SEL,
    input  logic                  WLAST_SEL,
    input  logic                  BVALID_SEL,
    input  logic                  BREADY_SEL,
    output logic [1:0]            grant_m,
    output logic [3:0]            slave_sel,
    output logic                  aw_en,
    output logic                  w_en,
    output logic                  b_en,
    output logic                  busy,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);

    state_t               state;
    logic [CNT_WIDTH-1:0] wd_cnt;
    logic                 prio_m1;      // 1: M1 wins a tie, 0: M0 wins a tie

    logic pick_m1;
    logic aw_valid_g;
    logic phase_hs;
    logic expired;
    logic unused_addr;

    // Map the 64 KiB region index onto the one-hot slave route.
    function automatic logic [3:0] decode_slave(input logic [ADDR_WIDTH-1:0] addr);
        case (addr[31:16])
            16'h0000: return 4'b0001;
            16'h0001: return 4'b0010;
            16'h0002: return 4'b0100;
            default:  return 4'b1000;
        endcase
    endfunction

    // Only the region bits steer routing; the rest of the address is data.
    assign unused_addr = ^{AWADDR_M0, AWADDR_M1};

    // Winner selection and per-phase handshake detection.
    always_comb begin
        pick_m1    = AWVALID_M1 & (~AWVALID_M0 | prio_m1);
        aw_valid_g = grant_m[1] ? AWVALID_M1 : AWVALID_M0;
        phase_hs   = 1'b0;
        case (state)
            ADDR:    phase_hs = aw_valid_g & AWREADY_SEL;
            DATA:    phase_hs = WVALID_SEL & WREADY_SEL;
            RESP:    phase_hs = BVALID_SEL & BREADY_SEL;
            default: phase_hs = 1'b0;
        endcase
        expired = (TIMEOUT != 0) && (wd_cnt == TIMEOUT_CNT);
    end

    // Transaction FSM; every output is a register updated with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wd_cnt      <= '0;
            prio_m1     <= 1'b0;
            grant_m     <= 2'b00;
            slave_sel   <= 4'b0000;
            aw_en       <= 1'b0;
            w_en        <= 1'b0;
            b_en        <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            if (state == IDLE) begin
                if (AWVALID_M0 | AWVALID_M1) begin
                    state     <= ADDR;
                    grant_m   <= pick_m1 ? 2'b10 : 2'b01;
                    slave_sel <= decode_slave(pick_m1 ? AWADDR_M1 : AWADDR_M0);
                    aw_en     <= 1'b1;
                    busy      <= 1'b1;
                    wd_cnt    <= '0;
                end
            end else if (phase_hs) begin
                // A handshake is progress, even on the cycle the watchdog expires.
                wd_cnt <= '0;
                case (state)
                    ADDR: begin
                        state <= DATA;
                        aw_en <= 1'b0;
                        w_en  <= 1'b1;
                    end
                    DATA: begin
                        if (WLAST_SEL) begin
                            state <= RESP;
                            w_en  <= 1'b0;
                            b_en  <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        grant_m   <= 2'b00;
                        slave_sel <= 4'b0000;
                        b_en      <= 1'b0;
                        busy      <= 1'b0;
                        prio_m1   <= grant_m[0];
                    end
                endcase
            end else if (expired) begin
                // Abort the stalled transaction and hand priority to the other master.
                state       <= IDLE;
                grant_m     <= 2'b00;
                slave_sel   <= 4'b0000;
                aw_en       <= 1'b0;
                w_en        <= 1'b0;
                b_en        <= 1'b0;
                busy        <= 1'b0;
                timeout_err <= 1'b1;
                prio_m1     <= grant_m[0];
                wd_cnt      <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Self-checking bench for axi_write_arbiter: directed scenarios plus a
// randomized transaction loop, checked against a transaction-level model.
module tb_axi_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        awvalid_m0, awvalid_m1;
    logic [31:0] awaddr_m0, awaddr_m1;
    logic        awready, wvalid, wready, wlast, bvalid, bready;
    logic [1:0]  grant_m;
    logic [3:0]  slave_sel;
    logic        aw_en, w_en, b_en, busy, timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int prio_m  = 0;   // master that wins when both request

    wire [10:0] obs = {grant_m, slave_sel, aw_en, w_en, b_en, busy, timeout_err};

    always #5 clk = ~clk;

    axi_write_arbiter #(.ADDR_WIDTH(32), .TIMEOUT(8), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst_n),
        .AWVALID_M0(awvalid_m0), .AWADDR_M0(awaddr_m0),
        .AWVALID_M1(awvalid_m1), .AWADDR_M1(awaddr_m1),
        .AWREADY_SEL(awready), .WVALID_SEL(wvalid), .WREADY_SEL(wready),
        .WLAST_SEL(wlast), .BVALID_SEL(bvalid), .BREADY_SEL(bready),
        .grant_m(grant_m), .slave_sel(slave_sel), .aw_en(aw_en), .w_en(w_en),
        .b_en(b_en), .busy(busy), .timeout_err(timeout_err)
    );

    function automatic logic [3:0] route_of(input logic [31:0] a);
        int region;
        region = int'(a >> 16);
        if (region == 0) return 4'b0001;
        if (region == 1) return 4'b0010;
        if (region == 2) return 4'b0100;
        return 4'b1000;
    endfunction

    // Expected output vector: phase 0 idle, 1 address, 2 data, 3 response.
    function automatic logic [10:0] outs(input int phase, input int m, input logic [31:0] a);
        logic [1:0] g;
        g = (m == 1) ? 2'b10 : 2'b01;
        case (phase)
            1:       return {g, route_of(a), 5'b10010};
            2:       return {g, route_of(a), 5'b01010};
            3:       return {g, route_of(a), 5'b00110};
            default: return 11'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Serve one write from master m, whose AWVALID/AWADDR are already driven.
    task automatic run_write(input int m, input logic [31:0] a, input int aw_wait,
                             input int beats, input int gap_max, input int b_wait,
                             input string name);
        logic [10:0] e;
        step();
        e = outs(1, m, a); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL %s grant: got %b want %b", name, obs, e); end
        awready = 1'b0;
        repeat (aw_wait) begin
            step();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL %s aw_stall: got %b want %b", name, obs, e); end
        end
        awready = 1'b1;
        step();
        awready = 1'b0;
        if (m == 0) awvalid_m0 = 1'b0; else awvalid_m1 = 1'b0;
        e = outs(2, m, a); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL %s aw_done: got %b want %b", name, obs, e); end
        for (int b = 0; b < beats; b++) begin
            repeat ($urandom_range(0, gap_max)) begin
                wvalid = 1'($urandom_range(0, 1));
                wready = ~wvalid;
                wlast  = 1'($urandom_range(0, 1));
                step();
                n_tests++;
                if (obs !== e) begin n_fail++; $display("FAIL %s w_stall: got %b want %b", name, obs, e); end
            end
            wvalid = 1'b1; wready = 1'b1; wlast = (b == beats - 1);
            step();
            wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
            e = outs((b == beats - 1) ? 3 : 2, m, a); n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL %s w_beat%0d: got %b want %b", name, b, obs, e); end
        end
        repeat (b_wait) begin
            bvalid = 1'($urandom_range(0, 1));
            bready = ~bvalid;
            step();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL %s b_stall: got %b want %b", name, obs, e); end
        end
        bvalid = 1'b1; bready = 1'b1;
        step();
        bvalid = 1'b0; bready = 1'b0;
        n_tests++;
        if (obs !== 11'b0) begin n_fail++; $display("FAIL %s b_done: got %b want %b", name, obs, 11'b0); end
        prio_m = 1 - m;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        awvalid_m0 = 1'b0; awvalid_m1 = 1'b0; awaddr_m0 = '0; awaddr_m1 = '0;
        awready = 1'b0; wvalid = 1'b0; wready = 1'b0; wlast = 1'b0; bvalid = 1'b0; bready = 1'b0;
        prio_m = 0;
        repeat (2) step();
        n_tests++;
        if (obs !== 11'b0) begin n_fail++; $display("FAIL reset_hold: got %b want %b", obs, 11'b0); end
        rst_n = 1'b1;
        step();
        n_tests++;
        if (obs !== 11'b0) begin n_fail++; $display("FAIL reset_idle: got %b want %b", obs, 11'b0); end
    endtask

    task automatic test_arbitration();
        for (int r = 0; r < 3; r++) begin
            int first;
            awaddr_m0 = 32'h0000_1000; awaddr_m1 = 32'h0002_2000;
            awvalid_m0 = 1'b1; awvalid_m1 = 1'b1;
            first = prio_m;
            run_write(first, first ? awaddr_m1 : awaddr_m0, 1, 2, 1, 1, "arb_first");
            run_write(1 - first, first ? awaddr_m0 : awaddr_m1, 0, 1, 1, 0, "arb_second");
        end
    endtask

    task automatic test_basic();
        awaddr_m0 = 32'h0001_0040; awvalid_m0 = 1'b1;
        run_write(0, awaddr_m0, 0, 4, 0, 0, "basic_m0");
    endtask

    task automatic test_default_slave();
        awaddr_m1 = 32'h0005_0000; awvalid_m1 = 1'b1;
        run_write(1, awaddr_m1, 2, 3, 2, 2, "default_slave");
    endtask

    task automatic test_timeout();
        logic [10:0] e;
        awaddr_m0 = 32'h0002_0000; awvalid_m0 = 1'b1;
        step();
        awready = 1'b1;
        step();
        awready = 1'b0; awvalid_m0 = 1'b0;
        wvalid = 1'b1; wready = 1'b0;
        e = outs(2, 0, awaddr_m0);
        for (int i = 0; i < 8; i++) begin
            step();
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL timeout_wait%0d: got %b want %b", i, obs, e); end
        end
        step();
        n_tests++;
        if (obs !== 11'b1) begin n_fail++; $display("FAIL timeout_pulse: got %b want %b", obs, 11'b1); end
        step();
        n_tests++;
        if (obs !== 11'b0) begin n_fail++; $display("FAIL timeout_after: got %b want %b", obs, 11'b0); end
        wvalid = 1'b0;
        prio_m = 1;
    endtask

    task automatic test_expiry_handshake();
        awaddr_m1 = 32'h0000_0004; awvalid_m1 = 1'b1;
        run_write(1, awaddr_m1, 8, 1, 0, 8, "expiry_boundary");
    endtask

    task automatic test_reset_mid();
        logic [10:0] e;
        awaddr_m0 = 32'h0000_0100; awvalid_m0 = 1'b1;
        run_write(0, awaddr_m0, 0, 1, 0, 0, "pre_reset");
        awaddr_m1 = 32'h0001_0000; awvalid_m1 = 1'b1;
        step();
        awready = 1'b1;
        step();
        awready = 1'b0; awvalid_m1 = 1'b0;
        e = outs(2, 1, awaddr_m1); n_tests++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_mid_data: got %b want %b", obs, e); end
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs !== 11'b0) begin n_fail++; $display("FAIL reset_async: got %b want %b", obs, 11'b0); end
        step();
        rst_n = 1'b1;
        prio_m = 0;
        awaddr_m0 = 32'h0002_0010; awaddr_m1 = 32'h0000_0020;
        awvalid_m0 = 1'b1; awvalid_m1 = 1'b1;
        run_write(0, awaddr_m0, 0, 1, 0, 0, "post_reset_m0");
        run_write(1, awaddr_m1, 0, 1, 0, 0, "post_reset_m1");
    endtask

    task automatic test_single_beat();
        int m;
        logic [31:0] a;
        m = prio_m;
        a = 32'h0001_0008;
        if (m == 0) begin awaddr_m0 = a; awvalid_m0 = 1'b1; end
        else begin awaddr_m1 = a; awvalid_m1 = 1'b1; end
        awready = 1'b1; wvalid = 1'b1; wready = 1'b1; wlast = 1'b1; bvalid = 1'b1; bready = 1'b1;
        step();
        n_tests++;
        if (obs !== outs(1, m, a)) begin n_fail++; $display("FAIL single_addr: got %b want %b", obs, outs(1, m, a)); end
        step();
        awvalid_m0 = 1'b0; awvalid_m1 = 1'b0;
        n_tests++;
        if (obs !== outs(2, m, a)) begin n_fail++; $display("FAIL single_data: got %b want %b", obs, outs(2, m, a)); end
        step();
        n_tests++;
        if (obs !== outs(3, m, a)) begin n_fail++; $display("FAIL single_resp: got %b want %b", obs, outs(3, m, a)); end
        step();
        awready = 1'b0; wvalid = 1'b0; wready = 1'b0; wlast = 1'b0; bvalid = 1'b0; bready = 1'b0;
        n_tests++;
        if (obs !== 11'b0) begin n_fail++; $display("FAIL single_idle: got %b want %b", obs, 11'b0); end
        prio_m = 1 - m;
    endtask

    task automatic test_random();
        logic [31:0] addr [2];
        logic [15:0] regions [4];
        for (int it = 0; it < 20; it++) begin
            bit [1:0] pend;
            pend = 2'($urandom_range(1, 3));
            for (int k = 0; k < 2; k++) begin
                regions[0] = 16'h0000; regions[1] = 16'h0001; regions[2] = 16'h0002;
                regions[3] = 16'($urandom_range(3, 65535));
                addr[k] = {regions[$urandom_range(0, 3)], 16'($urandom)};
            end
            awaddr_m0 = addr[0]; awaddr_m1 = addr[1];
            awvalid_m0 = pend[0]; awvalid_m1 = pend[1];
            while (pend != 2'b00) begin
                int w;
                w = (pend == 2'b11) ? prio_m : (pend[1] ? 1 : 0);
                run_write(w, addr[w], $urandom_range(0, 8), $urandom_range(1, 5), 4,
                          $urandom_range(0, 8), "random");
                pend[w] = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_basic();
        test_default_slave();
        test_timeout();
        test_expiry_handshake();
        test_reset_mid();
        test_single_beat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
